pq_stim_harness: RTL and testbench

Parametrised stimulus generator and result checker for priority-queue benchmarking on the FPGA. Sits between the user-clock domain top level and a push/pop priority-queue instance, generating push/pop traffic in one of several selectable modes, tracking queue occupancy so the DUT is never overfilled or popped empty, checking pop ordering, and compressing pop results into a signature register that can be routed to a pin. Successor to the fixed alternating push/pop stimulus with an XOR-reduced output.

---
 rtl/pq_stim_harness.sv | 222 ++++++++++++++++++++++
 tb/tb_pq_stim_harness.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_stim_harness.sv
// Push/pop traffic generator and pop-result checker for priority-queue benchmarking.
// Tracks DUT occupancy, checks min-order within FILL_DRAIN drains, folds results into a signature.
module pq_stim_harness #(
  parameter int PTW      = 16,
  parameter int MTW      = 15,
  parameter int CAPACITY = 21844,
  parameter int POP_LAT  = 1,
  parameter int CTW      = $clog2(CAPACITY + 1)
) (
  input  logic                 user_clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic [1:0]           i_mode,
  input  logic [CTW-1:0]       i_fill_target,
  output logic                 o_push,
  output logic [MTW+PTW-1:0]   o_push_data,
  output logic                 o_pop,
  input  logic [MTW+PTW-1:0]   i_pop_data,
  output logic [CTW-1:0]       o_occupancy,
  output logic [31:0]          o_pop_count,
  output logic [MTW+PTW-1:0]   o_signature,
  output logic                 o_order_err,
  output logic [15:0]          o_rounds
);
  localparam int DW = MTW + PTW;
  localparam logic [31:0]    LFSR_POLY = 32'h8020_0003;
  localparam logic [CTW-1:0] CAP       = CTW'(CAPACITY);

  typedef enum logic [1:0] {
    M_ALT  = 2'd0,
    M_FD   = 2'd1,
    M_RAND = 2'd2,
    M_IDLE = 2'd3
  } mode_e;

  typedef enum logic {FD_FILL = 1'b0, FD_DRAIN = 1'b1} fd_state_e;
  typedef enum logic {PH_PUSH = 1'b0, PH_POP = 1'b1}   phase_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [DW-1:0] rotl1(input logic [DW-1:0] s);
    return {s[DW-2:0], s[DW-1]};
  endfunction

  function automatic logic [CTW-1:0] sat_target(input logic [CTW-1:0] t);
    if (t == '0) return CTW'(1);
    if (t > CAP) return CAP;
    return t;
  endfunction

  logic             en_q;
  mode_e            mode_q;
  mode_e            mode_eff;
  fd_state_e        fd_state_q, fd_state_d;
  phase_e           phase_q, phase_d;
  logic             drain_first_q, drain_first_d;
  logic [CTW-1:0]   cnt_q, cnt_d;
  logic [CTW-1:0]   occ_q;
  logic [CTW-1:0]   fill_tgt;
  logic [31:0]      lfsr_q;
  logic [PTW-1:0]   alt_prio_q;
  logic [PTW-1:0]   prio_d;
  logic [MTW-1:0]   seq_q;
  logic             push_q, pop_q;
  logic [DW-1:0]    push_data_q;
  logic             pop_fd_q, pop_first_q;
  logic             push_req, pop_req, push_go, pop_go, round_done;
  logic [15:0]      rounds_q;

  logic [POP_LAT-1:0] vld_p, fd_p, first_p;
  logic               cap_vld, cap_fd, cap_first;
  logic [PTW-1:0]     cap_prio;
  logic [PTW-1:0]     prev_prio_q;
  logic [31:0]        pop_count_q;
  logic [DW-1:0]      sig_q;
  logic               err_q;

  // A mode change only takes effect on the enable rising edge.
  assign mode_eff = (i_enable && !en_q) ? mode_e'(i_mode) : mode_q;
  assign fill_tgt = sat_target(i_fill_target);
  assign prio_d   = (mode_eff == M_ALT) ? alt_prio_q : lfsr_q[PTW-1:0];

  always_ff @(posedge user_clk) begin
    if (rst) begin
      fd_state_q    <= FD_FILL;
      phase_q       <= PH_PUSH;
      drain_first_q <= 1'b0;
    end else begin
      fd_state_q    <= fd_state_d;
      phase_q       <= phase_d;
      drain_first_q <= drain_first_d;
    end
  end

  always_comb begin
    fd_state_d    = fd_state_q;
    phase_d       = phase_q;
    drain_first_d = drain_first_q;
    if (i_enable) begin
      if (mode_eff == M_ALT) begin
        phase_d = (phase_q == PH_PUSH) ? PH_POP : PH_PUSH;
      end
      if (mode_eff == M_FD) begin
        if (fd_state_q == FD_FILL) begin
          if (cnt_d >= fill_tgt) begin
            fd_state_d    = FD_DRAIN;
            drain_first_d = 1'b1;
          end
        end else begin
          if (pop_go) drain_first_d = 1'b0;
          if (cnt_d == '0) fd_state_d = FD_FILL;
        end
      end
    end
  end

  always_comb begin
    push_req = 1'b0;
    pop_req  = 1'b0;
    if (i_enable) begin
      unique case (mode_eff)
        M_ALT:   if (phase_q == PH_PUSH) push_req = 1'b1; else pop_req = 1'b1;
        M_FD:    if (fd_state_q == FD_FILL) push_req = 1'b1; else pop_req = 1'b1;
        M_RAND:  if (lfsr_q[31]) push_req = 1'b1; else pop_req = 1'b1;
        default: ;
      endcase
    end
    push_go = push_req && (cnt_q != CAP);
    pop_go  = pop_req && (cnt_q != '0);
    cnt_d   = cnt_q;
    if (push_go)     cnt_d = cnt_q + CTW'(1);
    else if (pop_go) cnt_d = cnt_q - CTW'(1);
    round_done = (mode_eff == M_FD) && (fd_state_q == FD_DRAIN) && pop_go && (cnt_d == '0);
  end

  // ---- issue stage: strobes, push data, occupancy ----
  always_ff @(posedge user_clk) begin
    if (rst) begin
      en_q        <= 1'b0;
      mode_q      <= M_ALT;
      cnt_q       <= '0;
      occ_q       <= '0;
      lfsr_q      <= 32'h1;
      alt_prio_q  <= '0;
      seq_q       <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      push_data_q <= '0;
      pop_fd_q    <= 1'b0;
      pop_first_q <= 1'b0;
      rounds_q    <= '0;
    end else begin
      en_q        <= i_enable;
      mode_q      <= mode_eff;
      cnt_q       <= cnt_d;
      occ_q       <= cnt_q;
      push_q      <= push_go;
      pop_q       <= pop_go;
      pop_fd_q    <= (mode_eff == M_FD);
      pop_first_q <= drain_first_q;
      if (i_enable) lfsr_q <= lfsr_next(lfsr_q);
      if (push_go) begin
        alt_prio_q  <= alt_prio_q + PTW'(1);
        seq_q       <= seq_q + MTW'(1);
        push_data_q <= {seq_q, prio_d};
      end
      if (round_done) rounds_q <= rounds_q + 16'd1;
    end
  end

  // ---- in-flight pop tracking, one slot per cycle of DUT latency ----
  always_ff @(posedge user_clk) begin
    if (rst) begin
      vld_p   <= '0;
      fd_p    <= '0;
      first_p <= '0;
    end else begin
      vld_p[0]   <= pop_q;
      fd_p[0]    <= pop_fd_q;
      first_p[0] <= pop_first_q;
      for (int i = 1; i < POP_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        fd_p[i]    <= fd_p[i-1];
        first_p[i] <= first_p[i-1];
      end
    end
  end

  assign cap_vld   = vld_p[POP_LAT-1];
  assign cap_fd    = fd_p[POP_LAT-1];
  assign cap_first = first_p[POP_LAT-1];
  assign cap_prio  = i_pop_data[PTW-1:0];

  // ---- capture stage: count, signature, ordering ----
  always_ff @(posedge user_clk) begin
    if (rst) begin
      pop_count_q <= '0;
      sig_q       <= '0;
      err_q       <= 1'b0;
    end else if (cap_vld) begin
      pop_count_q <= pop_count_q + 32'd1;
      sig_q       <= rotl1(sig_q) ^ i_pop_data;
      if (cap_fd && !cap_first && (cap_prio < prev_prio_q)) err_q <= 1'b1;
    end
  end

  always_ff @(posedge user_clk) begin
    if (cap_vld && cap_fd) prev_prio_q <= cap_prio;
  end

  assign o_push      = push_q;
  assign o_pop       = pop_q;
  assign o_push_data = push_data_q;
  assign o_occupancy = occ_q;
  assign o_pop_count = pop_count_q;
  assign o_signature = sig_q;
  assign o_order_err = err_q;
  assign o_rounds    = rounds_q;

endmodule

// File: tb/tb_pq_stim_harness.sv
// Directed bench for pq_stim_harness with a small min-queue model standing in for the DUT.
module tb_pq_stim_harness;
  localparam int PTW = 16;
  localparam int MTW = 15;
  localparam int CAP = 4;
  localparam int CTW = 4;
  localparam int DW  = MTW + PTW;

  logic              user_clk;
  logic              rst;
  logic              i_enable;
  logic [1:0]        i_mode;
  logic [CTW-1:0]    i_fill_target;
  logic              o_push;
  logic [DW-1:0]     o_push_data;
  logic              o_pop;
  logic [DW-1:0]     i_pop_data;
  logic [CTW-1:0]    o_occupancy;
  logic [31:0]       o_pop_count;
  logic [DW-1:0]     o_signature;
  logic              o_order_err;
  logic [15:0]       o_rounds;

  pq_stim_harness #(.PTW(PTW), .MTW(MTW), .CAPACITY(CAP), .POP_LAT(1), .CTW(CTW)) dut (
    .user_clk(user_clk), .rst(rst), .i_enable(i_enable), .i_mode(i_mode),
    .i_fill_target(i_fill_target), .o_push(o_push), .o_push_data(o_push_data),
    .o_pop(o_pop), .i_pop_data(i_pop_data), .o_occupancy(o_occupancy),
    .o_pop_count(o_pop_count), .o_signature(o_signature), .o_order_err(o_order_err),
    .o_rounds(o_rounds)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q_mem [0:15];
  int            q_n = 0;
  logic [DW-1:0] pend_data;
  bit            pend_vld = 0;
  logic [DW-1:0] forced [0:1];
  int            force_n = 0;
  int            force_i = 0;
  logic [DW-1:0] gsig;
  int            cnt_model;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; results for last cycle's pop are presented, then this cycle's strobes are modelled.
  task automatic tick();
    int mi;
    logic [DW-1:0] v;
    @(posedge user_clk);
    #1;
    if (pend_vld) begin
      i_pop_data = pend_data;
      pend_vld   = 0;
    end
    if (o_push && q_n < 16) begin
      q_mem[q_n] = o_push_data;
      q_n++;
    end
    if (o_pop) begin
      v = '0;
      if (q_n > 0) begin
        mi = 0;
        for (int i = 1; i < q_n; i++) if (q_mem[i][PTW-1:0] < q_mem[mi][PTW-1:0]) mi = i;
        v = q_mem[mi];
        for (int i = mi; i < q_n - 1; i++) q_mem[i] = q_mem[i+1];
        q_n--;
      end
      if (force_i < force_n) begin
        v = forced[force_i];
        force_i++;
      end
      pend_data = v;
      pend_vld  = 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_enable = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    q_n = 0;
    pend_vld = 0;
    force_n = 0;
    force_i = 0;
    i_pop_data = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    i_enable = 1'b0;
    i_mode = 2'd0;
    i_fill_target = '0;
    i_pop_data = '0;
    repeat (3) tick();
    chk("rst_push", o_push, 0);
    chk("rst_pop", o_pop, 0);
    chk("rst_pdata", o_push_data, 0);
    chk("rst_occ", o_occupancy, 0);
    chk("rst_cnt", o_pop_count, 0);
    chk("rst_sig", o_signature, 0);
    chk("rst_err", o_order_err, 0);
    chk("rst_rounds", o_rounds, 0);

    // ALTERNATE: push/pop alternate, data {seq, prio} = {i, i}
    rst = 1'b0;
    i_mode = 2'd0;
    i_enable = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("alt_push", o_push, (j % 2 == 0));
      chk("alt_pop", o_pop, (j % 2 == 1));
      chk("alt_occ", o_occupancy, j % 2);
      if (j % 2 == 0) chk("alt_data", o_push_data, {15'(j / 2), 16'(j / 2)});
    end
    i_enable = 1'b0;
    tick();
    chk("alt_stop", o_push | o_pop, 0);
    tick();
    gsig = '0;
    for (int i = 0; i < 8; i++) gsig = {gsig[DW-2:0], gsig[DW-1]} ^ {15'(i), 16'(i)};
    chk("alt_count", o_pop_count, 8);
    chk("alt_sig", o_signature, gsig);
    chk("alt_occ_end", o_occupancy, 0);

    // FILL_DRAIN target 3
    do_reset();
    i_mode = 2'd1;
    i_fill_target = 4'd3;
    i_enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("fd_push", o_push, (c % 6 < 3));
      chk("fd_pop", o_pop, (c % 6 >= 3));
      if (c == 3) chk("fd_occ_full", o_occupancy, 3);
    end
    i_enable = 1'b0;
    tick();
    tick();
    chk("fd_rounds", o_rounds, 2);
    chk("fd_err", o_order_err, 0);
    chk("fd_count", o_pop_count, 6);
    chk("fd_occ_end", o_occupancy, 0);

    // Ordering violation: model returns priority 5 then 2 in one drain
    do_reset();
    forced[0] = {15'd0, 16'd5};
    forced[1] = {15'd1, 16'd2};
    force_n = 2;
    i_mode = 2'd1;
    i_fill_target = 4'd2;
    i_enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("ord_pop", o_pop, (c >= 2));
    end
    i_enable = 1'b0;
    tick();
    chk("ord_err_early", o_order_err, 0);
    tick();
    chk("ord_err_set", o_order_err, 1);
    chk("ord_count", o_pop_count, 2);
    repeat (3) tick();
    chk("ord_err_sticky", o_order_err, 1);
    do_reset();
    chk("ord_err_clr", o_order_err, 0);

    // Target clamping: 0 behaves as 1
    i_mode = 2'd1;
    i_fill_target = 4'd0;
    i_enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("clamp0_push", o_push, (c % 2 == 0));
      chk("clamp0_pop", o_pop, (c % 2 == 1));
    end
    i_enable = 1'b0;
    tick();
    chk("clamp0_rounds", o_rounds, 2);

    // Target clamping: CAPACITY+5 behaves as CAPACITY
    do_reset();
    i_mode = 2'd1;
    i_fill_target = 4'(CAP + 5);
    i_enable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("clampH_push", o_push, (c < 4));
      chk("clampH_pop", o_pop, (c >= 4));
      if (c == 4) chk("clampH_occ", o_occupancy, CAP);
    end
    i_enable = 1'b0;
    tick();
    chk("clampH_rounds", o_rounds, 1);

    // rst mid-DRAIN with a pop in flight
    do_reset();
    i_mode = 2'd1;
    i_fill_target = 4'd3;
    i_enable = 1'b1;
    repeat (4) tick();
    chk("rstd_pop", o_pop, 1);
    rst = 1'b1;
    tick();
    chk("rstd_push", o_push, 0);
    chk("rstd_pop0", o_pop, 0);
    chk("rstd_pdata", o_push_data, 0);
    chk("rstd_occ", o_occupancy, 0);
    chk("rstd_cnt", o_pop_count, 0);
    chk("rstd_sig", o_signature, 0);
    chk("rstd_rounds", o_rounds, 0);
    rst = 1'b0;
    i_enable = 1'b0;
    q_n = 0;
    tick();
    chk("rstd_discard", o_pop_count, 0);
    tick();
    chk("rstd_discard2", o_pop_count, 0);
    i_enable = 1'b1;
    tick();
    chk("rstd_first_push", o_push, 1);
    chk("rstd_first_nopop", o_pop, 0);
    i_enable = 1'b0;

    // IDLE, with a mode change while enabled that must be ignored
    do_reset();
    i_mode = 2'd3;
    i_enable = 1'b1;
    tick();
    i_mode = 2'd0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("idle_push", o_push, 0);
      chk("idle_pop", o_pop, 0);
    end
    i_enable = 1'b0;

    // RANDOM: bounds respected and occupancy tracks issued ops
    do_reset();
    i_mode = 2'd2;
    i_enable = 1'b1;
    cnt_model = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      chk("rnd_occ", o_occupancy, cnt_model);
      chk("rnd_excl", o_push & o_pop, 0);
      if (o_push) chk("rnd_not_full", (cnt_model < CAP), 1);
      if (o_pop) chk("rnd_not_empty", (cnt_model > 0), 1);
      cnt_model = cnt_model + int'(o_push) - int'(o_pop);
    end
    i_enable = 1'b0;
    tick();
    chk("rnd_occ_end", o_occupancy, cnt_model);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
